// File: rtl/fetch_if_id.sv
// rtl/fetch_if_id.sv - instruction fetch stage with IF/ID pipeline register
//
// Owns the fetch PC, drives instruction memory and registers the fetched word
// with its PC and PC+4 for the decode stage.
//
// Ports:
//   clk            pipeline clock, all state changes on rising edge
//   reset          synchronous, active-high
//   imem_addr      instruction memory byte address (current pc, combinational)
//   imem_rdata     instruction word for imem_addr
//   imem_valid     imem_rdata is valid this cycle
//   stall          hold pc and IF/ID contents
//   redirect_valid taken branch/jump: flush IF/ID and refetch from redirect_pc
//   redirect_pc    redirect target (low two bits ignored)
//   id_instr       registered instruction (NOP_INSTR when slot invalid)
//   id_pc          registered PC of id_instr
//   id_pc_plus4    registered id_pc + 4 (link value)
//   id_valid       IF/ID slot holds a real instruction
//   pc             current fetch PC
module fetch_if_id #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic        id_valid,
   output logic [31:0] pc
);

   logic [31:0] r_pc;
   logic [31:0] r_id_instr;
   logic [31:0] r_id_pc;
   logic [31:0] r_id_pc_plus4;
   logic        r_id_valid;
   logic [31:0] w_pc_plus4;

   // Wraps modulo 2^32 naturally; no overflow indication is wanted.
   assign w_pc_plus4 = r_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_id_instr    <= NOP_INSTR;
         r_id_pc       <= 32'd0;
         r_id_pc_plus4 <= 32'd0;
         r_id_valid    <= 1'b0;
      end else if (redirect_valid) begin
         // Flush wins over stall; the word fetched this cycle is wrong-path.
         r_pc       <= {redirect_pc[31:2], 2'b00};
         r_id_instr <= NOP_INSTR;
         r_id_valid <= 1'b0;
      end else if (stall) begin
         // Hold everything; memory response is ignored and refetched later.
         r_pc <= r_pc;
      end else if (!imem_valid) begin
         // Wait state: keep pc so the same address is retried, send a bubble.
         r_id_instr <= NOP_INSTR;
         r_id_valid <= 1'b0;
      end else begin
         r_pc          <= w_pc_plus4;
         r_id_instr    <= imem_rdata;
         r_id_pc       <= r_pc;
         r_id_pc_plus4 <= w_pc_plus4;
         r_id_valid    <= 1'b1;
      end
   end

   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign id_instr    = r_id_instr;
   assign id_pc       = r_id_pc;
   assign id_pc_plus4 = r_id_pc_plus4;
   assign id_valid    = r_id_valid;

endmodule

// File: tb/tb_fetch_if_id.sv
// tb/tb_fetch_if_id.sv - scoreboard testbench for fetch_if_id
module tb_fetch_if_id;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        id_valid;
   logic [31:0] pc;

   int tests  = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] idpc;
      logic [31:0] idpc4;
      logic        v;
      logic        chk_pcs;
      int          step_no;
   } exp_t;

   exp_t q[$];
   int   step_cnt = 0;

   fetch_if_id #(
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(32'h0000_0013)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_valid    (imem_valid),
      .stall         (stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .id_instr      (id_instr),
      .id_pc         (id_pc),
      .id_pc_plus4   (id_pc_plus4),
      .id_valid      (id_valid),
      .pc            (pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int sn, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, sn, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue the state expected after the next edge.
   task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic iv, input logic [31:0] rd,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic [31:0] e_idpc, input logic [31:0] e_idpc4,
                       input logic e_v, input logic chk_pcs);
      exp_t e;
      @(negedge clk);
      reset          = rst;
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_valid     = iv;
      imem_rdata     = rd;
      step_cnt++;
      e.pc = e_pc; e.instr = e_instr; e.idpc = e_idpc; e.idpc4 = e_idpc4;
      e.v = e_v; e.chk_pcs = chk_pcs; e.step_no = step_cnt;
      q.push_back(e);
   endtask

   // Monitor: after every edge, compare DUT state against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pc",        e.step_no, pc,        e.pc);
            check("imem_addr", e.step_no, imem_addr, e.pc);
            check("id_valid",  e.step_no, {31'd0, id_valid}, {31'd0, e.v});
            check("id_instr",  e.step_no, id_instr,  e.instr);
            if (e.chk_pcs) begin
               check("id_pc",       e.step_no, id_pc,       e.idpc);
               check("id_pc_plus4", e.step_no, id_pc_plus4, e.idpc4);
            end
            if (!id_valid) check("nop_invariant", e.step_no, id_instr, NOP);
         end
      end
   end

   initial begin
      int budget;
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_valid = 1'b0; imem_rdata = '0;

      // rst st rv rpc           iv rdata          pc            instr          id_pc         id_pc4        v  chk
      step(1, 0, 0, 32'h0,        1, 32'h1111_1111, 32'h0,        NOP,           32'h0,        32'h0,        0, 1);
      step(1, 0, 0, 32'h0,        1, 32'h2222_2222, 32'h0,        NOP,           32'h0,        32'h0,        0, 1);
      step(1, 1, 1, 32'h80,       1, 32'h3333_3333, 32'h0,        NOP,           32'h0,        32'h0,        0, 1);
      // streaming from reset PC
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_0000, 32'h4,        32'hC0DE_0000, 32'h0,        32'h4,        1, 1);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_0004, 32'h8,        32'hC0DE_0004, 32'h4,        32'h8,        1, 1);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_0008, 32'hC,        32'hC0DE_0008, 32'h8,        32'hC,        1, 1);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_000C, 32'h10,       32'hC0DE_000C, 32'hC,        32'h10,       1, 1);
      // stall two cycles at pc 0x10 (imem_valid ignored either way)
      step(0, 1, 0, 32'h0,        1, 32'hBAD0_0010, 32'h10,       32'hC0DE_000C, 32'hC,        32'h10,       1, 1);
      step(0, 1, 0, 32'h0,        0, 32'hBAD1_0010, 32'h10,       32'hC0DE_000C, 32'hC,        32'h10,       1, 1);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_0010, 32'h14,       32'hC0DE_0010, 32'h10,       32'h14,       1, 1);
      // redirect with simultaneous stall, misaligned target
      step(0, 1, 1, 32'h103,      1, 32'hDEAD_BEEF, 32'h100,      NOP,           32'h10,       32'h14,       0, 1);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_0100, 32'h104,      32'hC0DE_0100, 32'h100,      32'h104,      1, 1);
      // redirect to 0x20 then three memory wait states
      step(0, 0, 1, 32'h20,       1, 32'hDEAD_0001, 32'h20,       NOP,           32'h100,      32'h104,      0, 1);
      step(0, 0, 0, 32'h0,        0, 32'hDEAD_0002, 32'h20,       NOP,           32'h0,        32'h0,        0, 0);
      step(0, 0, 0, 32'h0,        0, 32'hDEAD_0003, 32'h20,       NOP,           32'h0,        32'h0,        0, 0);
      step(0, 0, 0, 32'h0,        0, 32'hDEAD_0004, 32'h20,       NOP,           32'h0,        32'h0,        0, 0);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_0020, 32'h24,       32'hC0DE_0020, 32'h20,       32'h24,       1, 1);
      // wrap-around at top of address space
      step(0, 0, 1, 32'hFFFF_FFFE,1, 32'hDEAD_0005, 32'hFFFF_FFFC, NOP,          32'h20,       32'h24,       0, 1);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_FFFC, 32'h0,        32'hC0DE_FFFC, 32'hFFFF_FFFC,32'h0,        1, 1);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_0000, 32'h4,        32'hC0DE_0000, 32'h0,        32'h4,        1, 1);
      // reset during a stall with a valid slot at pc 0x40
      step(0, 0, 1, 32'h3C,       1, 32'hDEAD_0006, 32'h3C,       NOP,           32'h0,        32'h4,        0, 1);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_003C, 32'h40,       32'hC0DE_003C, 32'h3C,       32'h40,       1, 1);
      step(0, 1, 0, 32'h0,        1, 32'hDEAD_0007, 32'h40,       32'hC0DE_003C, 32'h3C,       32'h40,       1, 1);
      step(1, 1, 1, 32'h80,       1, 32'hDEAD_0008, 32'h0,        NOP,           32'h0,        32'h0,        0, 1);
      step(0, 0, 0, 32'h0,        1, 32'hC0DE_0000, 32'h4,        32'hC0DE_0000, 32'h0,        32'h4,        1, 1);

      budget = 20;
      while (q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      tests++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
